region_fill_engine: RTL

//   Parametrised successor to the full-screen filler. Writes a rectangular region of the

---
 rtl/region_fill_engine_pkg.sv | 43 ++++
 rtl/region_fill_engine_alnum_lfsr.sv | 29 ++
 rtl/region_fill_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/region_fill_engine_pkg.sv
// Shared types, constants and helpers for the region fill engine:
// mode encodings, FSM states, alphanumeric mapping and LFSR taps.
package region_fill_engine_pkg;

    // Bits needed to hold the values 0..n-1 (never less than one).
    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        MODE_BLANK   = 2'd0,
        MODE_RANDOM  = 2'd1,
        MODE_PATTERN = 2'd2,
        MODE_CONST   = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    localparam int          ALNUM_COUNT = 62;
    localparam int          ASCII_DIGIT = 48;
    localparam int          ASCII_UPPER = 65;
    localparam int          ASCII_LOWER = 97;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    // 0-9 -> '0'..'9', 10-35 -> 'A'..'Z', 36-61 -> 'a'..'z'.
    function automatic logic [7:0] alnum_map(input logic [5:0] v);
        logic [7:0] v8;
        v8 = {2'b00, v};
        if (v < 6'd10)      return 8'(ASCII_DIGIT) + v8;
        else if (v < 6'd36) return 8'(ASCII_UPPER - 10) + v8;
        else                return 8'(ASCII_LOWER - 36) + v8;
    endfunction

endpackage

// File: rtl/region_fill_engine_alnum_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) with its state reduced modulo 62
// to index the alphanumeric table; steps only when asked to.
module region_fill_engine_alnum_lfsr
    import region_fill_engine_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    output logic [5:0] v
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
        v = 6'(lfsr_q % 16'(ALNUM_COUNT));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= SEED;
        else          lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/region_fill_engine.sv
// Writes a clamped rectangular region of the character screen buffer in
// raster order over a valid/ready port, in blank/random/pattern/constant mode.
module region_fill_engine
    import region_fill_engine_pkg::*;
#(
    parameter int                    WIDTH      = 80,
    parameter int                    HEIGHT     = 60,
    parameter int                    CHAR_WIDTH = 8,
    parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR = 8'h20,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1,
    localparam int                   XW         = log2(WIDTH),
    localparam int                   YW         = log2(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [CHAR_WIDTH-1:0] fill_char,
    input  logic [XW-1:0]         x0,
    input  logic [XW-1:0]         x1,
    input  logic [YW-1:0]         y0,
    input  logic [YW-1:0]         y1,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [CHAR_WIDTH-1:0] c_out,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = XW + 1;

    fill_state_e           state_q, state_d;
    fill_mode_e            mode_q, mode_d;
    logic [XW-1:0]         x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0]         y_q, y_d, y0_q, y0_d, y1_q, y1_d;
    logic [CHAR_WIDTH-1:0] fchar_q, fchar_d;

    logic [XW-1:0]         x1_clamped;
    logic [YW-1:0]         y1_clamped;
    logic                  handshake;
    logic [5:0]            rand_v;
    logic [5:0]            pat_v;
    logic [SW-1:0]         pat_sum;
    logic [CHAR_WIDTH-1:0] char_sel;

    assign x1_clamped = (x1 > XW'(WIDTH - 1))  ? XW'(WIDTH - 1)  : x1;
    assign y1_clamped = (y1 > YW'(HEIGHT - 1)) ? YW'(HEIGHT - 1) : y1;
    assign handshake  = (state_q == ST_FILL) && wr_ready;

    // The generator also steps on a handshake in the abort cycle, since that write lands.
    region_fill_engine_alnum_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (handshake),
        .v       (rand_v)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fchar_d = fchar_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = fill_mode_e'(mode);
                    fchar_d = fill_char;
                    x0_d    = x0;
                    x1_d    = x1_clamped;
                    y0_d    = y0;
                    y1_d    = y1_clamped;
                    x_d     = x0;
                    y_d     = y0;
                    state_d = ((x0 > x1_clamped) || (y0 > y1_clamped)) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wr_ready) begin
                    if (x_q < x1_q) begin
                        x_d = x_q + XW'(1);
                    end else begin
                        x_d = x0_q;
                        if (y_q == y1_q) state_d = ST_DONE;
                        else             y_d     = y_q + YW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_BLANK;
            fchar_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fchar_q <= fchar_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

    // Data is a function of registered state only, so it holds still through stalls.
    always_comb begin
        pat_sum  = SW'(x_q) + SW'(y_q);
        pat_v    = 6'(pat_sum % SW'(ALNUM_COUNT));
        char_sel = BLANK_CHAR;
        unique case (mode_q)
            MODE_BLANK:   char_sel = BLANK_CHAR;
            MODE_RANDOM:  char_sel = CHAR_WIDTH'(alnum_map(rand_v));
            MODE_PATTERN: char_sel = CHAR_WIDTH'(alnum_map(pat_v));
            MODE_CONST:   char_sel = fchar_q;
            default:      char_sel = BLANK_CHAR;
        endcase
    end

    assign wr_valid = (state_q == ST_FILL);
    assign busy     = (state_q == ST_FILL);
    assign done     = (state_q == ST_DONE);
    assign x        = x_q;
    assign y        = y_q;
    assign c_out    = wr_valid ? char_sel : '0;

endmodule
